serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 69 ++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and default width for serial_adder
package serial_adder_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder with valid/ready handshake; define SERIAL_ADDER_OVF_EN to add the ovf port
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic cy, s, co, last;
  assign last = cnt == CW'(WIDTH - 1);
  fa_cell u_fa (.a(sa[0]), .b(sb[0]), .ci(cy), .s(s), .co(co));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    sum       = sr;
    c_out     = cy;
  end
  // sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      cy  <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      sa  <= a;
      sb  <= b;
      cy  <= c_in;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {s, sr[WIDTH-1:1]};
      cy  <= co;
      cnt <= cnt + 1'b1;
    end
`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= cy ^ co;
`endif
endmodule
